mem_writeback_buffer: RTL and testbench

// - Per-port load-response queue directly upstream of the memory writeback mux.
// - Accepts load results from one memory port over a valid/ready handshake and formats them
//   (byte/word select, sign/zero extend).
// - Presents the result to the mux as a writeback request (ACK out) and retires it on grant (REQ in).
// - Decouples memory latency from regfile write-port arbitration; one instance per mux input port.

---
 rtl/mem_writeback_buffer_if.sv | 32 +++
 rtl/mem_writeback_buffer.sv | 74 +++++++
 tb/tb_mem_writeback_buffer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_writeback_buffer_if.sv
// mem_writeback_buffer_if: memory-response and writeback-mux handshake bundle for one buffer port
interface mem_writeback_buffer_if #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int PTRWIDTH        = 2,
    parameter int BYTESELWIDTH    = 1
);
    logic                       MemRespValid;
    logic                       MemRespReady;
    logic [DATABITWIDTH-1:0]    MemRespData;
    logic [REGADDRBITWIDTH-1:0] MemRespAddr;
    logic                       MemRespByteMode;
    logic                       MemRespSigned;
    logic [BYTESELWIDTH-1:0]    MemRespByteSel;
    logic                       MemWritebackACK;
    logic                       MemWritebackREQ;
    logic [DATABITWIDTH-1:0]    MemWritebackDataOut;
    logic [REGADDRBITWIDTH-1:0] MemWritebackAddrOut;
    logic [PTRWIDTH:0]          BufferCount;

    modport master (
        output MemRespValid, MemRespData, MemRespAddr, MemRespByteMode, MemRespSigned,
               MemRespByteSel, MemWritebackREQ,
        input  MemRespReady, MemWritebackACK, MemWritebackDataOut, MemWritebackAddrOut, BufferCount
    );

    modport slave (
        input  MemRespValid, MemRespData, MemRespAddr, MemRespByteMode, MemRespSigned,
               MemRespByteSel, MemWritebackREQ,
        output MemRespReady, MemWritebackACK, MemWritebackDataOut, MemWritebackAddrOut, BufferCount
    );
endinterface

// File: rtl/mem_writeback_buffer.sv
// mem_writeback_buffer: load-response FIFO that formats loads and requests the writeback mux.
// Define MEM_WRITEBACK_BYPASS_EN to forward a response straight to the mux when the queue is empty.
module mem_writeback_buffer #(
    parameter int DATABITWIDTH    = 16,
    parameter int REGADDRBITWIDTH = 4,
    parameter int DEPTH           = 4,
    parameter int PTRWIDTH        = 2,
    parameter int BYTESELWIDTH    = 1
) (
    input logic                   clk,
    input logic                   clk_en,
    input logic                   sync_rst,
    mem_writeback_buffer_if.slave bus
);
    localparam logic [PTRWIDTH:0] FULL = (PTRWIDTH+1)'(DEPTH);

    logic [DATABITWIDTH-1:0]    data_q [DEPTH];
    logic [REGADDRBITWIDTH-1:0] addr_q [DEPTH];
    logic [PTRWIDTH-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTRWIDTH:0]          count_q, count_d;
    logic [7:0]                 byte_w;
    logic [DATABITWIDTH-1:0]    fmt_w;
    logic                       byp, ready, ack, push, pop;

    assign byte_w = 8'(bus.MemRespData >> {bus.MemRespByteSel, 3'b000});
    assign fmt_w  = bus.MemRespByteMode ?
                    {{(DATABITWIDTH-8){bus.MemRespSigned & byte_w[7]}}, byte_w} : bus.MemRespData;

`ifdef MEM_WRITEBACK_BYPASS_EN
    assign byp = clk_en & (count_q == '0) & bus.MemRespValid;
    assign bus.MemWritebackDataOut = byp ? fmt_w : data_q[rd_ptr_q];
    assign bus.MemWritebackAddrOut = byp ? bus.MemRespAddr : addr_q[rd_ptr_q];
`else
    assign byp = 1'b0;
    assign bus.MemWritebackDataOut = data_q[rd_ptr_q];
    assign bus.MemWritebackAddrOut = addr_q[rd_ptr_q];
`endif

    assign ready = clk_en & (count_q != FULL);
    assign ack   = (clk_en & (count_q != '0)) | byp;
    // a granted bypass consumes the response outright, so neither pointer moves
    assign push  = bus.MemRespValid & ready & ~(byp & bus.MemWritebackREQ);
    assign pop   = ack & bus.MemWritebackREQ & ~byp;

    assign bus.MemRespReady    = ready;
    assign bus.MemWritebackACK = ack;
    assign bus.BufferCount     = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = (push & ~pop) ? count_q + 1'b1 : (pop & ~push) ? count_q - 1'b1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                addr_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                data_q[wr_ptr_q] <= fmt_w;
                addr_q[wr_ptr_q] <= bus.MemRespAddr;
            end
        end
    end
endmodule

// File: tb/tb_mem_writeback_buffer.sv
// tb_mem_writeback_buffer: queue-model scoreboard plus directed literal checks for mem_writeback_buffer.
module tb_mem_writeback_buffer;
    localparam int DW = 16, AW = 4, DEPTH = 4;
`ifdef MEM_WRITEBACK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic clk_en, sync_rst;
    int errors = 0, checks = 0;
    logic [DW+AW-1:0] mq[$];
    bit model_ok = 1'b0;
    bit exp_ready, exp_ack, byp_m, m_push, m_pop;
    logic [DW+AW-1:0] exp_e;

    mem_writeback_buffer_if #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(AW), .PTRWIDTH(2), .BYTESELWIDTH(1)) bus();

    mem_writeback_buffer #(.DATABITWIDTH(DW), .REGADDRBITWIDTH(AW), .DEPTH(DEPTH), .PTRWIDTH(2),
                           .BYTESELWIDTH(1)) dut (
        .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] fmt(input logic [DW-1:0] d, input logic bm, input logic sg,
                                          input logic sel);
        int b;
        b = (int'(d) >> (8 * int'(sel))) & 255;
        if (!bm) return d;
        return (sg && b >= 128) ? DW'(b + 'hFF00) : DW'(b);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input bit v, input logic [DW-1:0] d, input logic [AW-1:0] a, input bit bm,
                       input bit sg, input bit sel, input bit r);
        @(negedge clk);
        bus.MemRespValid    = v;
        bus.MemRespData     = d;
        bus.MemRespAddr     = a;
        bus.MemRespByteMode = bm;
        bus.MemRespSigned   = sg;
        bus.MemRespByteSel  = sel;
        bus.MemWritebackREQ = r;
    endtask

    // scoreboard: outputs checked mid-low-phase, model advanced on each rising edge
    always begin
        @(negedge clk);
        #2;
        if (model_ok) begin
            byp_m     = BYP && clk_en && mq.size() == 0 && bus.MemRespValid;
            exp_ready = clk_en && mq.size() != DEPTH;
            exp_ack   = (clk_en && mq.size() != 0) || byp_m;
            chk("ready", bus.MemRespReady, exp_ready);
            chk("ack", bus.MemWritebackACK, exp_ack);
            chk("count", bus.BufferCount, mq.size());
            if (exp_ack) begin
                exp_e = byp_m ? {bus.MemRespAddr, fmt(bus.MemRespData, bus.MemRespByteMode,
                                 bus.MemRespSigned, bus.MemRespByteSel)} : mq[0];
                chk("data", bus.MemWritebackDataOut, exp_e[DW-1:0]);
                chk("addr", bus.MemWritebackAddrOut, exp_e[DW+AW-1:DW]);
            end
        end
        @(posedge clk);
        if (sync_rst) begin
            mq.delete();
            model_ok = 1'b1;
        end else if (clk_en && !(BYP && mq.size() == 0 && bus.MemRespValid && bus.MemWritebackREQ)) begin
            m_push = bus.MemRespValid && mq.size() != DEPTH;
            m_pop  = bus.MemWritebackREQ && mq.size() != 0;
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back({bus.MemRespAddr, fmt(bus.MemRespData, bus.MemRespByteMode,
                                      bus.MemRespSigned, bus.MemRespByteSel)});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clk_en = 1'b1;
        sync_rst = 1'b1;
        bus.MemRespValid = 1'b1;
        bus.MemRespData = 16'h1234;
        bus.MemRespAddr = 4'd3;
        bus.MemRespByteMode = 1'b0;
        bus.MemRespSigned = 1'b0;
        bus.MemRespByteSel = 1'b0;
        bus.MemWritebackREQ = 1'b0;
        repeat (2) @(negedge clk);
        drv(0, 0, 0, 0, 0, 0, 0);
        sync_rst = 1'b0;
        #3;
        chk("rst_ack", bus.MemWritebackACK, 0);
        chk("rst_count", bus.BufferCount, 0);
        chk("rst_ready", bus.MemRespReady, 1);
        chk("rst_data", bus.MemWritebackDataOut, 0);
        chk("rst_addr", bus.MemWritebackAddrOut, 0);

        drv(1, 16'hBEEF, 5, 0, 0, 0, 1);
        #3;
        chk("wl_ack0", bus.MemWritebackACK, BYP);
        chk("wl_data0", bus.MemWritebackDataOut, BYP ? 16'hBEEF : 16'h0);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("wl_ack1", bus.MemWritebackACK, !BYP);
        chk("wl_data1", bus.MemWritebackDataOut, BYP ? 16'h0 : 16'hBEEF);
        chk("wl_addr1", bus.MemWritebackAddrOut, BYP ? 0 : 5);
        chk("wl_count1", bus.BufferCount, !BYP);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3;
        chk("wl_ack2", bus.MemWritebackACK, 0);

        drv(1, 16'h80F3, 1, 1, 1, 1, 0);
        drv(1, 16'h80F3, 2, 1, 0, 1, 0);
        drv(1, 16'h80F3, 3, 1, 1, 0, 0);
        drv(1, 16'h80F3, 4, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3 chk("byte_s1", bus.MemWritebackDataOut, 16'hFF80);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3 chk("byte_u1", bus.MemWritebackDataOut, 16'h0080);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3 chk("byte_s0", bus.MemWritebackDataOut, 16'hFFF3);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3 chk("byte_u0", bus.MemWritebackDataOut, 16'h00F3);
        chk("byte_addr", bus.MemWritebackAddrOut, 4);

        for (int i = 0; i < 5; i++) begin
            drv(1, DW'(16'h1111 * (i + 1)), AW'(i), 0, 0, 0, 0);
            #3 chk("fill_ready", bus.MemRespReady, i < 4);
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 0, 0, 0, 0, 1);
            #3;
            chk("drain_data", bus.MemWritebackDataOut, 16'h1111 * (i + 1));
            chk("drain_ready", bus.MemRespReady, i > 0);
        end
        drv(0, 0, 0, 0, 0, 0, 0);

        drv(1, 16'hA000, 6, 0, 0, 0, 0);
        drv(1, 16'hA001, 7, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            drv(1, DW'(16'hA002 + i), AW'(i), 0, 0, 0, 1);
            #3;
            chk("steady_count", bus.BufferCount, 2);
            chk("steady_data", bus.MemWritebackDataOut, 16'hA000 + i);
        end
        drv(0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, 0, 0);

        drv(1, 16'hC001, 1, 0, 0, 0, 0);
        drv(1, 16'hC002, 2, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drv(1, 16'hC0FF, 9, 0, 0, 0, 1);
            clk_en = 1'b0;
            #3;
            chk("en_ack", bus.MemWritebackACK, 0);
            chk("en_ready", bus.MemRespReady, 0);
            chk("en_count", bus.BufferCount, 2);
        end
        drv(0, 0, 0, 0, 0, 0, 1);
        clk_en = 1'b1;
        #3 chk("en_resume1", bus.MemWritebackDataOut, 16'hC001);
        drv(0, 0, 0, 0, 0, 0, 1);
        #3 chk("en_resume2", bus.MemWritebackDataOut, 16'hC002);
        drv(0, 0, 0, 0, 0, 0, 0);

        drv(1, 16'hD001, 1, 0, 0, 0, 0);
        drv(1, 16'hD002, 2, 0, 0, 0, 0);
        drv(1, 16'hD003, 3, 0, 0, 0, 1);
        sync_rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        sync_rst = 1'b0;
        #3;
        chk("midrst_count", bus.BufferCount, 0);
        chk("midrst_ack", bus.MemWritebackACK, 0);

        repeat (400) begin
            drv($urandom_range(0, 9) < 7, DW'($urandom), AW'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom), $urandom_range(0, 9) < 6);
            clk_en = $urandom_range(0, 7) != 0;
            sync_rst = $urandom_range(0, 63) == 0;
        end
        drv(0, 0, 0, 0, 0, 0, 0);
        clk_en = 1'b1;
        sync_rst = 1'b0;
        repeat (2) @(negedge clk);
        #4;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
